// File: rtl/half_adder_pkg.sv
// Shared types and defaults for the registered lane-parallel half adder.
package half_adder_pkg;

  localparam int unsigned HA_DEFAULT_WIDTH = 1;
  localparam int unsigned HA_DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_lane_t;

  function automatic ha_lane_t ha_eval(input logic a, input logic b);
    ha_lane_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder; one instance per lane.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  ha_lane_t lane;

  assign lane = ha_eval(a, b);
  assign s    = lane.sum;
  assign c    = lane.carry;

endmodule

// File: rtl/half_adder_core.sv
// Registered lane-parallel half adder with 1-cycle latency.
// Define HALF_ADDER_STATS_EN to build the saturating carry_count statistics counter.
module half_adder_core
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HA_DEFAULT_WIDTH
`ifdef HALF_ADDER_STATS_EN
  , parameter int unsigned CNT_W = HA_DEFAULT_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
`ifdef HALF_ADDER_STATS_EN
  , output logic [CNT_W-1:0] carry_count
`endif
);

  logic [WIDTH-1:0] lane_s;
  logic [WIDTH-1:0] lane_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (lane_s[i]),
      .c (lane_c[i])
    );
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             valid_q, valid_d;

  // Results hold while no input is accepted; valid only flags the fresh cycle.
  always_comb begin
    s_d     = s_q;
    c_d     = c_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d = lane_s;
      c_d = lane_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign c         = c_q;
  assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|lane_c) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder_core.sv
// Directed self-checking bench for half_adder_core (stats checks built with HALF_ADDER_STATS_EN).
module tb_half_adder_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;

  logic [0:0] q_s  [4];
  logic [0:0] q_c  [4];
  logic       q_ov [4];
  logic [3:0] w_s, w_c;
  logic       w_ov;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

`ifdef HALF_ADDER_STATS_EN
  logic [15:0] q_cnt [4];
  logic [15:0] w_cnt;
  logic [0:0]  st_s, st_c;
  logic        st_ov;
  logic [1:0]  st_cnt;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_quad
    half_adder_core #(
      .WIDTH (1)
    ) u_dut (
`ifdef HALF_ADDER_STATS_EN
      .carry_count (q_cnt[i]),
`endif
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a1),
      .b         (b1),
      .out_valid (q_ov[i]),
      .s         (q_s[i]),
      .c         (q_c[i])
    );
  end

  half_adder_core #(
    .WIDTH (4)
  ) u_dut_w4 (
`ifdef HALF_ADDER_STATS_EN
    .carry_count (w_cnt),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .out_valid (w_ov),
    .s         (w_s),
    .c         (w_c)
  );

`ifdef HALF_ADDER_STATS_EN
  half_adder_core #(
    .WIDTH (1),
    .CNT_W (2)
  ) u_dut_stats (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a1),
    .b           (b1),
    .out_valid   (st_ov),
    .s           (st_s),
    .c           (st_c),
    .carry_count (st_cnt)
  );
`endif

  task automatic test_reset();
    logic [11:0] quad;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hf; b4 = 4'hf;
    @(posedge clk); #1;
    quad = {q_ov[3], q_ov[2], q_ov[1], q_ov[0], q_s[3], q_s[2], q_s[1], q_s[0],
            q_c[3], q_c[2], q_c[1], q_c[0]};
    n_total++;
    if (quad !== 12'h000) $display("FAIL reset_quad got %h want 000", quad);
    else n_pass++;
    n_total++;
    if ({w_ov, w_s, w_c} !== 9'h000) $display("FAIL reset_w4 got %h want 000", {w_ov, w_s, w_c});
    else n_pass++;
`ifdef HALF_ADDER_STATS_EN
    n_total++;
    if ({st_ov, st_s, st_c, st_cnt} !== 5'b0) $display("FAIL reset_stats got %b want 00000",
                                                      {st_ov, st_s, st_c, st_cnt});
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] vec_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp_s  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_c  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] qv, qs, qc;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      in_valid = 1'b1; {a1, b1} = vec_ab[v];
      @(posedge clk); #1;
      qv = {q_ov[3], q_ov[2], q_ov[1], q_ov[0]};
      qs = {q_s[3], q_s[2], q_s[1], q_s[0]};
      qc = {q_c[3], q_c[2], q_c[1], q_c[0]};
      n_total++;
      if ({qv, qs, qc} !== {4'hf, {4{exp_s[v]}}, {4{exp_c[v]}}})
        $display("FAIL truth_apply_%0d got ov=%b s=%b c=%b want ov=1111 s=%b c=%b",
                 v, qv, qs, qc, {4{exp_s[v]}}, {4{exp_c[v]}});
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0; a1 = ~a1; b1 = ~b1;
      repeat (8) @(negedge clk);
      qv = {q_ov[3], q_ov[2], q_ov[1], q_ov[0]};
      qs = {q_s[3], q_s[2], q_s[1], q_s[0]};
      qc = {q_c[3], q_c[2], q_c[1], q_c[0]};
      n_total++;
      if ({qv, qs, qc} !== {4'h0, {4{exp_s[v]}}, {4{exp_c[v]}}})
        $display("FAIL truth_hold_%0d got ov=%b s=%b c=%b want ov=0000 s=%b c=%b",
                 v, qv, qs, qc, {4{exp_s[v]}}, {4{exp_c[v]}});
      else n_pass++;
    end
  endtask

  task automatic test_width4();
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    @(posedge clk); #1;
    n_total++;
    if ({w_ov, w_s, w_c} !== {1'b1, 4'b0110, 4'b1000})
      $display("FAIL w4_result got ov=%b s=%b c=%b want ov=1 s=0110 c=1000", w_ov, w_s, w_c);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; a4 = 4'b1111; b4 = 4'b1111;
    @(posedge clk); #1;
    n_total++;
    if ({w_ov, w_s, w_c} !== {1'b0, 4'b0110, 4'b1000})
      $display("FAIL w4_hold got ov=%b s=%b c=%b want ov=0 s=0110 c=1000", w_ov, w_s, w_c);
    else n_pass++;
  endtask

`ifdef HALF_ADDER_STATS_EN
  task automatic test_stats();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (st_cnt !== exp_cnt[k]) $display("FAIL stats_count_%0d got %0d want %0d",
                                          k, st_cnt, exp_cnt[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (st_cnt !== 2'd0) $display("FAIL stats_reset got %0d want 0", st_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask
`endif

  task automatic test_midstream_reset();
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'b0011; b4 = 4'b0001; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({w_ov, w_s, w_c} !== {1'b1, 4'b0010, 4'b0001})
      $display("FAIL mid_pre got ov=%b s=%b c=%b want ov=1 s=0010 c=0001", w_ov, w_s, w_c);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1; a4 = 4'b1111; b4 = 4'b1111; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({w_ov, w_s, w_c, q_ov[0], q_s[0], q_c[0]} !== 12'h000)
      $display("FAIL mid_rst got %h want 000", {w_ov, w_s, w_c, q_ov[0], q_s[0], q_c[0]});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; a4 = 4'b0101; b4 = 4'b0110; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({w_ov, w_s, w_c} !== {1'b1, 4'b0011, 4'b0100})
      $display("FAIL mid_post_w4 got ov=%b s=%b c=%b want ov=1 s=0011 c=0100", w_ov, w_s, w_c);
    else n_pass++;
    n_total++;
    if ({q_ov[0], q_s[0], q_c[0]} !== 3'b110)
      $display("FAIL mid_post_w1 got %b want 110", {q_ov[0], q_s[0], q_c[0]});
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    test_reset();
    test_truth_table();
    test_width4();
`ifdef HALF_ADDER_STATS_EN
    test_stats();
`endif
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
